// File: rtl/mac_window_quantizer.sv
// Window sampler for the mac accumulator: differences successive window-end snapshots,
// applies ReLU/shift/saturation and queues the activations in a small valid/ready FIFO.
module mac_window_quantizer #(
    parameter int ACC_W   = 12,
    parameter int OUT_W   = 4,
    parameter int VEC_LEN = 4,
    parameter int SHIFT   = 2,
    parameter int DEPTH   = 2,
    parameter int CNT_W   = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             en,
    input  logic [ACC_W-1:0] mac_out,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] win_cnt,
    output logic             overflow
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FCNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0]  LAST_POS = CNT_W'(VEC_LEN - 1);
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [FCNT_W-1:0] FULL_CNT = FCNT_W'(DEPTH);
    localparam logic [ACC_W-1:0]  SAT_MAX  = ACC_W'((1 << (OUT_W - 1)) - 1);

    logic [CNT_W-1:0]  r_win_cnt;
    logic [ACC_W-1:0]  r_prev_snap;
    logic [ACC_W-1:0]  r_s1_data;
    logic              r_s1_valid;
    logic [OUT_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [FCNT_W-1:0] r_count;
    logic              r_overflow;

    logic                    w_sample;
    logic [ACC_W-1:0]        w_delta;
    logic signed [ACC_W-1:0] w_s1_signed;
    logic signed [ACC_W-1:0] w_shifted;
    logic [OUT_W-1:0]        w_q;
    logic                    w_empty;
    logic                    w_full;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_drop;

    assign w_sample = en && (r_win_cnt == LAST_POS);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_win_cnt <= '0;
        end else if (en) begin
            r_win_cnt <= (r_win_cnt == LAST_POS) ? '0 : r_win_cnt + 1'b1;
        end
    end

    // Modulo subtraction recovers the window sum even if the accumulator wrapped in between.
    assign w_delta = mac_out - r_prev_snap;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_prev_snap <= '0;
            r_s1_data   <= '0;
            r_s1_valid  <= 1'b0;
        end else begin
            r_s1_valid <= w_sample;
            if (w_sample) begin
                r_prev_snap <= mac_out;
                r_s1_data   <= w_delta;
            end
        end
    end

    assign w_s1_signed = r_s1_data;
    assign w_shifted   = w_s1_signed >>> SHIFT;

    always_comb begin
        w_q = '0;
        if (!r_s1_data[ACC_W-1]) begin
            if ($unsigned(w_shifted) > SAT_MAX) begin
                w_q = SAT_MAX[OUT_W-1:0];
            end else begin
                w_q = w_shifted[OUT_W-1:0];
            end
        end
    end

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    assign w_pop   = !w_empty && out_ready;
    // A full FIFO still accepts the new result when the head leaves in the same cycle.
    assign w_push  = r_s1_valid && (!w_full || w_pop);
    assign w_drop  = r_s1_valid && w_full && !w_pop;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_q;
        end
    end

    assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign out_valid = !w_empty;
    assign win_cnt   = r_win_cnt;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_mac_window_quantizer.sv
// Scenario bench for mac_window_quantizer against a queue-based behavioural model.
module tb_mac_window_quantizer;

    localparam int VEC_LEN = 4;
    localparam int DEPTH   = 2;

    logic        clk = 1'b0;
    logic        rstb;
    logic        en;
    logic [11:0] mac_out;
    logic [3:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  win_cnt;
    logic        overflow;

    int n_vec = 0;
    int n_err = 0;

    int m_cnt;
    int m_prev;
    bit m_s1_v;
    int m_s1_q;
    int m_fifo[$];
    bit m_ovf;

    always #5 clk = ~clk;

    mac_window_quantizer dut (
        .clk       (clk),
        .rstb      (rstb),
        .en        (en),
        .mac_out   (mac_out),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .win_cnt   (win_cnt),
        .overflow  (overflow)
    );

    function automatic int wrap12(int v);
        int r;
        r = v & 4095;
        if (r >= 2048) r = r - 4096;
        return r;
    endfunction

    function automatic int quant(int delta);
        int q;
        if (delta < 0) return 0;
        q = delta / 4;
        if (q > 7) q = 7;
        return q;
    endfunction

    function automatic int exp_data();
        return (m_fifo.size() > 0) ? m_fifo[0] : 0;
    endfunction

    function automatic bit exp_valid();
        return m_fifo.size() > 0;
    endfunction

    task automatic model_reset();
        m_cnt  = 0;
        m_prev = 0;
        m_s1_v = 0;
        m_s1_q = 0;
        m_fifo.delete();
        m_ovf  = 0;
    endtask

    // Drive one clock of stimulus and advance the model across that edge.
    task automatic step(input bit e, input int mac, input bit rdy);
        bit pop;
        bit full;
        en        = e;
        mac_out   = 12'(mac);
        out_ready = rdy;
        pop  = (m_fifo.size() > 0) && rdy;
        full = (m_fifo.size() == DEPTH);
        if (pop) void'(m_fifo.pop_front());
        if (m_s1_v) begin
            if (full && !pop) m_ovf = 1;
            else m_fifo.push_back(m_s1_q);
        end
        if (e && m_cnt == VEC_LEN - 1) begin
            m_s1_q = quant(wrap12(mac - m_prev));
            m_prev = wrap12(mac);
            m_s1_v = 1;
        end else begin
            m_s1_v = 0;
        end
        if (e) m_cnt = (m_cnt + 1) % VEC_LEN;
        @(posedge clk);
        #1;
    endtask

    task automatic run_window(input int mac, input bit rdy);
        for (int i = 0; i < VEC_LEN; i++) step(1'b1, mac, rdy);
    endtask

    task automatic apply_reset();
        rstb      = 1'b0;
        en        = 1'b0;
        out_ready = 1'b0;
        mac_out   = '0;
        model_reset();
        #2;
        @(posedge clk);
        #1;
        rstb = 1'b1;
    endtask

    task automatic test_reset();
        rstb = 1'b0; en = 1'b0; out_ready = 1'b0; mac_out = '0;
        model_reset();
        #2;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
        n_vec++; if (out_data !== 4'd0) begin n_err++; $display("FAIL reset_data: got %0d expected 0", out_data); end
        n_vec++; if (win_cnt !== 2'd0) begin n_err++; $display("FAIL reset_wincnt: got %0d expected 0", win_cnt); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %0b expected 0", overflow); end
        @(posedge clk);
        #1;
        rstb = 1'b1;
        run_window(40, 1'b0);
        step(1'b0, 40, 1'b0);
        step(1'b1, 40, 1'b0);
        step(1'b1, 40, 1'b0);
        n_vec++; if (out_valid !== 1'b1 || out_data !== 4'd7) begin n_err++; $display("FAIL prereset_fifo: got valid=%0b data=%0d expected valid=1 data=7", out_valid, out_data); end
        n_vec++; if (win_cnt !== 2'd2) begin n_err++; $display("FAIL prereset_wincnt: got %0d expected 2", win_cnt); end
        #2;
        rstb = 1'b0;
        model_reset();
        #1;
        n_vec++; if (out_valid !== 1'b0 || out_data !== 4'd0) begin n_err++; $display("FAIL async_reset_out: got valid=%0b data=%0d expected valid=0 data=0", out_valid, out_data); end
        n_vec++; if (win_cnt !== 2'd0) begin n_err++; $display("FAIL async_reset_wincnt: got %0d expected 0", win_cnt); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL async_reset_ovf: got %0b expected 0", overflow); end
        @(posedge clk);
        #1;
        rstb = 1'b1;
    endtask

    task automatic test_basic();
        apply_reset();
        for (int i = 0; i < VEC_LEN - 1; i++) step(1'b1, 40, 1'b1);
        step(1'b1, 40, 1'b1);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_latency_early: got valid=%0b expected 0", out_valid); end
        step(1'b0, 40, 1'b1);
        n_vec++; if (out_valid !== 1'b1 || out_data !== 4'd7) begin n_err++; $display("FAIL basic_sat: got valid=%0b data=%0d expected valid=1 data=7", out_valid, out_data); end
        run_window(52, 1'b1);
        step(1'b0, 52, 1'b1);
        n_vec++; if (out_valid !== 1'b1 || out_data !== 4'd3) begin n_err++; $display("FAIL basic_delta12: got valid=%0b data=%0d expected valid=1 data=3", out_valid, out_data); end
    endtask

    task automatic test_relu();
        run_window(30, 1'b1);
        step(1'b0, 30, 1'b1);
        n_vec++; if (out_valid !== 1'b1 || out_data !== 4'd0) begin n_err++; $display("FAIL relu: got valid=%0b data=%0d expected valid=1 data=0", out_valid, out_data); end
    endtask

    task automatic test_wrap();
        run_window(2040, 1'b1);
        step(1'b0, 2040, 1'b1);
        n_vec++; if (out_data !== 4'(exp_data())) begin n_err++; $display("FAIL wrap_setup: got %0d expected %0d", out_data, exp_data()); end
        run_window(-2040, 1'b1);
        step(1'b0, -2040, 1'b1);
        n_vec++; if (out_valid !== 1'b1 || out_data !== 4'd4) begin n_err++; $display("FAIL wrap_delta16: got valid=%0b data=%0d expected valid=1 data=4", out_valid, out_data); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        run_window(4, 1'b0);
        run_window(12, 1'b0);
        run_window(24, 1'b0);
        step(1'b0, 24, 1'b0);
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL bp_overflow: got %0b expected 1", overflow); end
        n_vec++; if (out_valid !== 1'b1 || out_data !== 4'd1) begin n_err++; $display("FAIL bp_head1: got valid=%0b data=%0d expected valid=1 data=1", out_valid, out_data); end
        step(1'b0, 24, 1'b1);
        n_vec++; if (out_valid !== 1'b1 || out_data !== 4'd2) begin n_err++; $display("FAIL bp_head2: got valid=%0b data=%0d expected valid=1 data=2", out_valid, out_data); end
        step(1'b0, 24, 1'b1);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drained: got valid=%0b expected 0", out_valid); end
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL bp_sticky: got %0b expected 1", overflow); end
    endtask

    task automatic test_enable_gating();
        apply_reset();
        step(1'b1, 20, 1'b1);
        step(1'b1, 20, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 20, 1'b1);
            n_vec++; if (win_cnt !== 2'd2 || out_valid !== 1'b0) begin n_err++; $display("FAIL en_hold[%0d]: got cnt=%0d valid=%0b expected cnt=2 valid=0", i, win_cnt, out_valid); end
        end
        step(1'b1, 20, 1'b1);
        step(1'b1, 20, 1'b1);
        n_vec++; if (win_cnt !== 2'd0) begin n_err++; $display("FAIL en_wrap: got %0d expected 0", win_cnt); end
        step(1'b0, 20, 1'b1);
        n_vec++; if (out_valid !== 1'b1 || out_data !== 4'd5) begin n_err++; $display("FAIL en_result: got valid=%0b data=%0d expected valid=1 data=5", out_valid, out_data); end
    endtask

    task automatic test_random();
        int acc;
        bit e;
        bit rdy;
        apply_reset();
        acc = 0;
        for (int i = 0; i < 600; i++) begin
            e   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) == 0);
            if (e) acc = wrap12(acc + int'($urandom_range(0, 800)) - 400);
            step(e, acc, rdy);
            n_vec++; if (out_valid !== exp_valid()) begin n_err++; $display("FAIL rnd_valid[%0d]: got %0b expected %0b", i, out_valid, exp_valid()); end
            n_vec++; if (out_data !== 4'(exp_data())) begin n_err++; $display("FAIL rnd_data[%0d]: got %0d expected %0d", i, out_data, exp_data()); end
            n_vec++; if (win_cnt !== 2'(m_cnt)) begin n_err++; $display("FAIL rnd_wincnt[%0d]: got %0d expected %0d", i, win_cnt, m_cnt); end
            n_vec++; if (overflow !== m_ovf) begin n_err++; $display("FAIL rnd_ovf[%0d]: got %0b expected %0b", i, overflow, m_ovf); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_relu();
        test_wrap();
        test_backpressure();
        test_enable_gating();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
